vx_barrier_ctrl: RTL and testbench

Per-core barrier controller for warp synchronisation. It accepts barrier instructions from the warp-control path as `barrier_t`, tracks arriving warps per barrier id, and holds them stalled. It releases them to the warp scheduler once the barrier's warp count is reached. For global barriers it adds a request/response handshake with the cluster-level barrier unit before release.

---
 rtl/vx_barrier_ctrl_pkg.sv | 41 ++++
 rtl/vx_gbar_fsm.sv | 70 +++++++
 rtl/vx_barrier_ctrl.sv | 152 +++++++++++++++
 tb/tb_vx_barrier_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_barrier_ctrl_pkg.sv
// Shared types for the per-core barrier controller and its cluster-level
// global barrier handshake.
package vx_barrier_ctrl_pkg;

  localparam int CFG_NUM_WARPS    = 4;
  localparam int CFG_NUM_BARRIERS = 4;
  localparam int NW_WIDTH = (CFG_NUM_WARPS > 1) ? $clog2(CFG_NUM_WARPS) : 1;
  localparam int NB_WIDTH = (CFG_NUM_BARRIERS > 1) ? $clog2(CFG_NUM_BARRIERS) : 1;

  // Barrier instruction as delivered by the warp-control path.
  typedef struct packed {
    logic                valid;
    logic [NB_WIDTH-1:0] id;
    logic                is_global;
    logic [NW_WIDTH-1:0] size_m1;
    logic                is_noop;
  } barrier_t;

  // Request to the cluster-level barrier unit.
  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NW_WIDTH-1:0] size_m1;
  } gbar_req_t;

  // Completion from the cluster-level barrier unit.
  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_rsp_t;

  typedef enum logic [1:0] {
    GBAR_IDLE  = 2'd0,
    GBAR_GREQ  = 2'd1,
    GBAR_GWAIT = 2'd2
  } gbar_state_e;

  // One-hot warp mask for a warp id.
  function automatic logic [CFG_NUM_WARPS-1:0] warp_bit(input logic [NW_WIDTH-1:0] wid);
    return CFG_NUM_WARPS'(1) << wid;
  endfunction

endpackage

// File: rtl/vx_gbar_fsm.sv
// Global barrier handshake: holds one outstanding global barrier, issues the
// request to the cluster unit and flags the matching completion.
module vx_gbar_fsm
  import vx_barrier_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [NB_WIDTH-1:0] i_id,
  input  logic [NW_WIDTH-1:0] i_size_m1,
  input  logic                i_req_ready,
  input  logic                i_rsp_valid,
  input  logic [NB_WIDTH-1:0] i_rsp_id,
  output logic                o_busy,
  output logic                o_req_valid,
  output logic [NB_WIDTH-1:0] o_req_id,
  output logic [NW_WIDTH-1:0] o_req_size_m1,
  output logic                o_rel,
  output logic [NB_WIDTH-1:0] o_rel_id
);

  gbar_state_e r_state;
  gbar_state_e w_state_next;
  gbar_req_t   r_req;
  gbar_rsp_t   w_rsp;
  logic        r_req_valid;
  logic        w_rel;

  assign w_rsp = '{id: i_rsp_id};

  // Next-state and completion decode; a response for another id is ignored.
  always_comb begin
    w_state_next = r_state;
    w_rel        = 1'b0;
    case (r_state)
      GBAR_IDLE:  if (i_start) w_state_next = GBAR_GREQ;
      GBAR_GREQ:  if (i_req_ready) w_state_next = GBAR_GWAIT;
      GBAR_GWAIT: begin
        if (i_rsp_valid && (w_rsp.id == r_req.id)) begin
          w_rel        = 1'b1;
          w_state_next = GBAR_IDLE;
        end
      end
      default:    w_state_next = GBAR_IDLE;
    endcase
  end

  // State register, registered request valid and the latched request fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= GBAR_IDLE;
      r_req_valid <= 1'b0;
      r_req       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_req_valid <= (w_state_next == GBAR_GREQ);
      if (i_start && (r_state == GBAR_IDLE)) begin
        r_req <= '{id: i_id, size_m1: i_size_m1};
      end
    end
  end

  assign o_busy        = (r_state != GBAR_IDLE);
  assign o_req_valid   = r_req_valid;
  assign o_req_id      = r_req.id;
  assign o_req_size_m1 = r_req.size_m1;
  assign o_rel         = w_rel;
  assign o_rel_id      = r_req.id;

endmodule

// File: rtl/vx_barrier_ctrl.sv
// Per-core barrier controller: tracks arriving warps per barrier id, stalls
// them, and releases them locally or after the cluster-level handshake.
module vx_barrier_ctrl
  import vx_barrier_ctrl_pkg::*;
#(
  parameter int NUM_WARPS    = CFG_NUM_WARPS,
  parameter int NUM_BARRIERS = CFG_NUM_BARRIERS
)(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         bar_valid,
  output logic                         bar_ready,
  input  logic [NW_WIDTH-1:0]          bar_wid,
  input  logic [$bits(barrier_t)-1:0]  bar_req,
  output logic                         gbar_req_valid,
  input  logic                         gbar_req_ready,
  output logic [NB_WIDTH-1:0]          gbar_req_id,
  output logic [NW_WIDTH-1:0]          gbar_req_size_m1,
  input  logic                         gbar_rsp_valid,
  input  logic [NB_WIDTH-1:0]          gbar_rsp_id,
  output logic [NUM_WARPS-1:0]         stalled_wmask,
  output logic                         release_valid,
  output logic [NUM_WARPS-1:0]         release_wmask
);

  barrier_t w_req;
  logic     w_unused_valid;
  logic     w_gbar_busy;
  logic     w_grel;
  logic [NB_WIDTH-1:0] w_grel_id;

  assign w_req          = barrier_t'(bar_req);
  // The instruction's own valid bit is superseded by bar_valid.
  assign w_unused_valid = w_req.valid;

  // Only one global barrier can be in flight; later global ones wait.
  assign bar_ready = !(w_gbar_busy && w_req.is_global);

  logic                 w_arrive;
  logic [NUM_WARPS-1:0] w_wid_bit;
  assign w_arrive  = bar_valid && bar_ready && !w_req.is_noop;
  assign w_wid_bit = warp_bit(bar_wid);

  // Per-barrier storage (flattened so each generate slice owns its slot).
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] w_mask_q;
  logic [NUM_BARRIERS-1:0][NW_WIDTH-1:0]  w_count_q;
  // Mask as seen by a new arrival: a global release this cycle empties it
  // first, so a same-cycle arrival starts the next round.
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] w_base_mask;

  logic [NUM_WARPS-1:0] w_cur_base;
  logic [NW_WIDTH-1:0]  w_cur_count;
  logic                 w_dup;
  logic                 w_final;
  logic                 w_take;
  logic                 w_gstart;
  logic [NUM_WARPS-1:0] w_local_rel;
  logic [NUM_WARPS-1:0] w_global_rel;
  logic [NUM_WARPS-1:0] w_rel;
  logic [NUM_WARPS-1:0] w_stall_set;

  assign w_cur_base  = w_base_mask[w_req.id];
  assign w_cur_count = w_count_q[w_req.id];
  assign w_dup       = |(w_cur_base & w_wid_bit);
  assign w_final     = (w_cur_count == w_req.size_m1);
  // A duplicate arrival changes nothing; the warp simply stays stalled.
  assign w_take      = w_arrive && !w_dup;
  assign w_gstart    = w_take && w_final && w_req.is_global;

  assign w_local_rel  = (w_take && w_final && !w_req.is_global) ? (w_cur_base | w_wid_bit) : '0;
  assign w_global_rel = w_grel ? w_mask_q[w_grel_id] : '0;
  assign w_rel        = w_local_rel | w_global_rel;
  // Every taken arrival stalls except a final local one, which leaves at once.
  assign w_stall_set  = (w_take && !(w_final && !w_req.is_global)) ? w_wid_bit : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
      logic [NUM_WARPS-1:0] r_wait_mask;
      logic [NW_WIDTH-1:0]  r_count;
      logic                 w_hit;

      assign w_hit           = w_take && (w_req.id == NB_WIDTH'(gi));
      assign w_base_mask[gi] = (w_grel && (w_grel_id == NB_WIDTH'(gi))) ? '0 : r_wait_mask;
      assign w_mask_q[gi]    = r_wait_mask;
      assign w_count_q[gi]   = r_count;

      // Arrival bookkeeping for this barrier id.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_wait_mask <= '0;
          r_count     <= '0;
        end else if (w_hit) begin
          if (!w_final) begin
            r_wait_mask <= w_base_mask[gi] | w_wid_bit;
            r_count     <= r_count + 1'b1;
          end else if (w_req.is_global) begin
            // Held until the cluster unit answers; counting restarts now.
            r_wait_mask <= w_base_mask[gi] | w_wid_bit;
            r_count     <= '0;
          end else begin
            r_wait_mask <= '0;
            r_count     <= '0;
          end
        end else begin
          r_wait_mask <= w_base_mask[gi];
        end
      end
    end
  endgenerate

  vx_gbar_fsm u_gbar_fsm (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (w_gstart),
    .i_id          (w_req.id),
    .i_size_m1     (w_req.size_m1),
    .i_req_ready   (gbar_req_ready),
    .i_rsp_valid   (gbar_rsp_valid),
    .i_rsp_id      (gbar_rsp_id),
    .o_busy        (w_gbar_busy),
    .o_req_valid   (gbar_req_valid),
    .o_req_id      (gbar_req_id),
    .o_req_size_m1 (gbar_req_size_m1),
    .o_rel         (w_grel),
    .o_rel_id      (w_grel_id)
  );

  logic [NUM_WARPS-1:0] r_stalled;
  logic                 r_release_valid;
  logic [NUM_WARPS-1:0] r_release_wmask;

  // Registered stall mask and release pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stalled       <= '0;
      r_release_valid <= 1'b0;
      r_release_wmask <= '0;
    end else begin
      r_stalled       <= (r_stalled & ~w_rel) | w_stall_set;
      r_release_valid <= |w_rel;
      r_release_wmask <= w_rel;
    end
  end

  assign stalled_wmask = r_stalled;
  assign release_valid = r_release_valid;
  assign release_wmask = r_release_wmask;

  a_no_dup_arrival: assert property (@(posedge clk) disable iff (!reset_n) !(w_arrive && w_dup));

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Self-checking bench: directed scenarios followed by random traffic, checked
// against a set-based barrier model and a release scoreboard.
module tb_vx_barrier_ctrl;
  import vx_barrier_ctrl_pkg::*;

  localparam int NW = CFG_NUM_WARPS;
  localparam int NB = CFG_NUM_BARRIERS;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic bar_valid = 1'b0;
  logic bar_ready;
  logic [NW_WIDTH-1:0] bar_wid = '0;
  barrier_t req_s = '0;
  logic [$bits(barrier_t)-1:0] bar_req;
  logic gbar_req_valid;
  logic gbar_req_ready = 1'b0;
  logic [NB_WIDTH-1:0] gbar_req_id;
  logic [NW_WIDTH-1:0] gbar_req_size_m1;
  logic gbar_rsp_valid = 1'b0;
  logic [NB_WIDTH-1:0] gbar_rsp_id = '0;
  logic [NW-1:0] stalled_wmask;
  logic release_valid;
  logic [NW-1:0] release_wmask;

  assign bar_req = req_s;

  always #5 clk = ~clk;

  vx_barrier_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bar_valid        (bar_valid),
    .bar_ready        (bar_ready),
    .bar_wid          (bar_wid),
    .bar_req          (bar_req),
    .gbar_req_valid   (gbar_req_valid),
    .gbar_req_ready   (gbar_req_ready),
    .gbar_req_id      (gbar_req_id),
    .gbar_req_size_m1 (gbar_req_size_m1),
    .gbar_rsp_valid   (gbar_rsp_valid),
    .gbar_rsp_id      (gbar_rsp_id),
    .stalled_wmask    (stalled_wmask),
    .release_valid    (release_valid),
    .release_wmask    (release_wmask)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic note_fail(input string name, input int act, input int expv);
    checks++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // ---------------- reference model ----------------
  // Each barrier round is the set of warps that have arrived; a round closes
  // when the set already holds size_m1 warps. Closed global rounds wait for
  // the cluster response before their warps leave.
  int unsigned m_members [NB];
  int          m_size    [NB];
  int unsigned m_stalled = 0;
  bit          m_greq = 0;
  bit          m_gwait = 0;
  int          m_gid = 0;
  int          m_gsize = 0;
  int unsigned m_gmask = 0;
  longint      cyc = 0;

  typedef struct {
    int unsigned mask;
    longint      due;
  } exp_t;
  exp_t sb[$];

  initial begin
    for (int b = 0; b < NB; b++) begin
      m_members[b] = 0;
      m_size[b] = 0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    int unsigned rel;
    int unsigned wbit;
    int          id;
    bit          busy;
    exp_t        e;
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) m_members[b] = 0;
      m_stalled = 0;
      m_greq = 0;
      m_gwait = 0;
      m_gmask = 0;
      sb.delete();
    end else begin
      rel = 0;
      busy = m_greq || m_gwait;
      if (m_gwait && gbar_rsp_valid && (int'(gbar_rsp_id) == m_gid)) begin
        rel |= m_gmask;
        m_gmask = 0;
        m_gwait = 0;
      end else if (m_greq && gbar_req_ready) begin
        m_greq = 0;
        m_gwait = 1;
      end
      if (bar_valid && !(busy && req_s.is_global) && !req_s.is_noop) begin
        wbit = 1 << bar_wid;
        id = int'(req_s.id);
        if ($countones(m_members[id]) == int'(req_s.size_m1)) begin
          if (req_s.is_global) begin
            m_gmask = m_members[id] | wbit;
            m_gid = id;
            m_gsize = int'(req_s.size_m1);
            m_greq = 1;
            m_stalled |= wbit;
          end else begin
            rel |= m_members[id] | wbit;
          end
          m_members[id] = 0;
        end else begin
          m_members[id] |= wbit;
          m_stalled |= wbit;
        end
      end
      m_stalled &= ~rel;
      if (rel != 0) begin
        e.mask = rel;
        e.due = cyc + 1;
        sb.push_back(e);
      end
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    check("stalled_wmask", int'(stalled_wmask), int'(m_stalled));
    check("gbar_req_valid", int'(gbar_req_valid), int'(m_greq));
    if (m_greq) begin
      check("gbar_req_id", int'(gbar_req_id), m_gid);
      check("gbar_req_size_m1", int'(gbar_req_size_m1), m_gsize);
    end
    if (bar_valid && reset_n)
      check("bar_ready", int'(bar_ready), int'(!((m_greq || m_gwait) && req_s.is_global)));
    if (release_valid) begin
      if (sb.size() == 0) begin
        note_fail("release_unexpected", int'(release_wmask), 0);
      end else begin
        e = sb.pop_front();
        $display("release cyc=%0d mask=0x%0h expected=0x%0h", cyc, release_wmask, e.mask);
        check("release_wmask", int'(release_wmask), int'(e.mask));
        check("release_cycle", int'(cyc), int'(e.due));
      end
    end else begin
      check("release_idle_mask", int'(release_wmask), 0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        note_fail("release_missing", 0, int'(sb[0].mask));
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int wid, input int id, input bit glob, input int size, input bit noop);
    bar_valid = 1'b1;
    bar_wid = NW_WIDTH'(wid);
    req_s.valid = 1'b1;
    req_s.id = NB_WIDTH'(id);
    req_s.is_global = glob;
    req_s.size_m1 = NW_WIDTH'(size);
    req_s.is_noop = noop;
  endtask

  task automatic undrive();
    bar_valid = 1'b0;
    req_s = '0;
  endtask

  task automatic issue(input int wid, input int id, input bit glob, input int size, input bit noop);
    drive(wid, id, glob, size, noop);
    $display("issue w%0d id%0d glob=%0d size_m1=%0d noop=%0d", wid, id, glob, size, noop);
    step();
    undrive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned free_m;
    int w;
    int id;
    int sz;
    int starve;

    #2 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check("rst_stalled", int'(stalled_wmask), 0);
    check("rst_release_valid", int'(release_valid), 0);
    check("rst_gbar_req_valid", int'(gbar_req_valid), 0);

    // Local 4-warp barrier on id 1.
    issue(0, 1, 0, 3, 0);
    issue(1, 1, 0, 3, 0);
    issue(2, 1, 0, 3, 0);
    check("local_stalled_3", int'(stalled_wmask), 'h7);
    check("local_no_release_yet", int'(release_valid), 0);
    issue(3, 1, 0, 3, 0);
    check("local_release_valid", int'(release_valid), 1);
    check("local_release_mask", int'(release_wmask), 'hF);
    check("local_stall_cleared", int'(stalled_wmask), 0);
    step();
    check("local_pulse_one_cycle", int'(release_valid), 0);

    // Noop and trivial barriers.
    issue(1, 0, 0, 0, 1);
    check("noop_no_release", int'(release_valid), 0);
    check("noop_no_stall", int'(stalled_wmask), 0);
    issue(2, 3, 0, 0, 0);
    check("trivial_release_mask", int'(release_wmask), 'h4);
    check("trivial_no_stall", int'(stalled_wmask), 0);
    step();

    // Global barrier id 2, two warps, request held for 3 cycles.
    issue(0, 2, 1, 1, 0);
    check("global_first_stall", int'(stalled_wmask), 'h1);
    check("global_no_req_yet", int'(gbar_req_valid), 0);
    issue(1, 2, 1, 1, 0);
    check("global_req_valid", int'(gbar_req_valid), 1);
    check("global_req_id", int'(gbar_req_id), 2);
    check("global_req_size", int'(gbar_req_size_m1), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("global_req_held", int'(gbar_req_valid), 1);
    end
    gbar_req_ready = 1'b1;
    step();
    gbar_req_ready = 1'b0;
    check("global_req_dropped", int'(gbar_req_valid), 0);

    // Back-pressure on a second global while the first is outstanding.
    drive(2, 0, 1, 1, 0);
    #1;
    check("bp_global_not_ready", int'(bar_ready), 0);
    step();
    undrive();
    issue(2, 0, 0, 1, 0);
    check("bp_local_accepted", int'(stalled_wmask), 'h7);

    // A response for another id is ignored.
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id = 2'd3;
    step();
    gbar_rsp_valid = 1'b0;
    check("rsp_mismatch_ignored", int'(release_valid), 0);

    // Local final on id 0 coincides with the matching global response.
    drive(3, 0, 0, 1, 0);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id = 2'd2;
    step();
    undrive();
    gbar_rsp_valid = 1'b0;
    check("concurrent_release_mask", int'(release_wmask), 'hF);
    check("concurrent_stall_cleared", int'(stalled_wmask), 0);
    step();

    // Interleaved barriers 0 and 1.
    issue(0, 0, 0, 2, 0);
    issue(1, 1, 0, 1, 0);
    issue(2, 0, 0, 2, 0);
    check("interleave_stalled", int'(stalled_wmask), 'h7);
    issue(3, 1, 0, 1, 0);
    check("interleave_release", int'(release_wmask), 'hA);
    check("interleave_remaining", int'(stalled_wmask), 'h5);

    // Reset while warps are waiting.
    reset_n = 1'b0;
    #1;
    check("reset_mid_stall", int'(stalled_wmask), 0);
    check("reset_mid_release", int'(release_valid), 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Random traffic.
    starve = 0;
    for (int c = 0; c < 3000; c++) begin
      gbar_req_ready = ($urandom_range(2, 0) == 0);
      gbar_rsp_valid = ($urandom_range(2, 0) == 0);
      gbar_rsp_id = ($urandom_range(1, 0) == 0) ? NB_WIDTH'(m_gid) : NB_WIDTH'($urandom_range(NB - 1, 0));
      undrive();
      free_m = ~m_stalled & ((1 << NW) - 1);
      if (free_m == 0 && !(m_greq || m_gwait)) starve++;
      else starve = 0;
      if (starve > 3 || $urandom_range(499, 0) == 0) begin
        $display("random reset at cyc=%0d", cyc);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        starve = 0;
      end else if (free_m != 0 && $urandom_range(3, 0) != 0) begin
        w = $urandom_range(NW - 1, 0);
        while (free_m[w] == 1'b0) w = (w + 1) % NW;
        id = $urandom_range(NB - 1, 0);
        while ((m_greq || m_gwait) && id == m_gid) id = (id + 1) % NB;
        if (m_members[id] == 0) m_size[id] = $urandom_range(NW - 1, 0);
        sz = m_size[id];
        issue(w, id, ($urandom_range(3, 0) == 0), sz, ($urandom_range(7, 0) == 0));
      end else begin
        step();
      end
    end

    undrive();
    gbar_req_ready = 1'b0;
    gbar_rsp_valid = 1'b0;
    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
